// File: rtl/imem_loader_if.sv
// Byte-stream / IM-write-port bundle for the instruction-memory loader.
// The master is the byte source and controller. The slave is the loader.
interface imem_loader_if #(
  parameter int unsigned ADDR_W = 10
);
  logic              Start;
  logic [7:0]        ByteIn;
  logic              ByteValid;
  logic              ByteReady;
  logic              ImWe;
  logic [ADDR_W-1:0] ImWAdr;
  logic [31:0]       ImWData;
  logic              CpuHold;
  logic              Busy;
  logic              Done;
  logic              Err;

  modport master (
    output Start, ByteIn, ByteValid,
    input  ByteReady, ImWe, ImWAdr, ImWData, CpuHold, Busy, Done, Err
  );

  modport slave (
    input  Start, ByteIn, ByteValid,
    output ByteReady, ImWe, ImWAdr, ImWData, CpuHold, Busy, Done, Err
  );
endinterface

// File: rtl/imem_loader.sv
// Instruction-memory loader.
// It receives a framed byte stream: COUNT_HI, COUNT_LO, COUNT big-endian words, and an
// XOR checksum. It writes each word into the IM write port and holds the CPU in reset
// while a session is running or has failed.
module imem_loader #(
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned TIMEOUT_CYC = 100000
) (
  input  logic          Clk,
  input  logic          Reset,
  imem_loader_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR_HI, S_HDR_LO, S_DATA, S_CHK, S_DONE, S_ERR
  } state_t;

  state_t            state_q, state_d;
  logic [15:0]       count_q, count_d;
  logic [ADDR_W:0]   widx_q,  widx_d;
  logic [1:0]        bidx_q,  bidx_d;
  logic [7:0]        csum_q,  csum_d;
  logic [31:0]       word_q,  word_d;
  logic [31:0]       tmo_q,   tmo_d;
  logic              we_q,    we_d;
  logic [ADDR_W-1:0] wadr_q,  wadr_d;
  logic [31:0]       wdata_q, wdata_d;

  logic        active;
  logic        accept;
  logic [15:0] cnt_new;
  logic        last_word;

  // Readiness is decoded from the state register only, so it never depends on ByteValid.
  assign active    = (state_q == S_HDR_HI) || (state_q == S_HDR_LO) ||
                     (state_q == S_DATA)   || (state_q == S_CHK);
  assign accept    = active && bus.ByteValid;
  assign cnt_new   = {count_q[15:8], bus.ByteIn};
  assign last_word = (32'(widx_q) == (32'(count_q) - 32'd1));

  assign bus.ByteReady = active;
  assign bus.Busy      = active;
  assign bus.Done      = (state_q == S_DONE);
  assign bus.Err       = (state_q == S_ERR);
  assign bus.CpuHold   = active || (state_q == S_ERR);
  assign bus.ImWe      = we_q;
  assign bus.ImWAdr    = wadr_q;
  assign bus.ImWData   = wdata_q;

  // Next-state logic for frame parsing, word assembly, checksum, and the idle timeout.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    widx_d  = widx_q;
    bidx_d  = bidx_q;
    csum_d  = csum_q;
    word_d  = word_q;
    tmo_d   = tmo_q;
    we_d    = 1'b0;
    wadr_d  = wadr_q;
    wdata_d = wdata_q;

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (bus.Start) begin
          state_d = S_HDR_HI;
          count_d = '0;
          widx_d  = '0;
          bidx_d  = '0;
          csum_d  = '0;
          tmo_d   = '0;
        end
      end
      S_HDR_HI: begin
        if (accept) begin
          count_d = {bus.ByteIn, 8'h00};
          csum_d  = csum_q ^ bus.ByteIn;
          state_d = S_HDR_LO;
        end
      end
      S_HDR_LO: begin
        if (accept) begin
          count_d = cnt_new;
          csum_d  = csum_q ^ bus.ByteIn;
          if (cnt_new == 16'd0)            state_d = S_CHK;
          else if (32'(cnt_new) > DEPTH)   state_d = S_ERR;
          else                             state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (accept) begin
          csum_d = csum_q ^ bus.ByteIn;
          bidx_d = bidx_q + 2'd1;
          case (bidx_q)
            2'd0:    word_d[31:24] = bus.ByteIn;
            2'd1:    word_d[23:16] = bus.ByteIn;
            2'd2:    word_d[15:8]  = bus.ByteIn;
            default: begin
              word_d[7:0] = bus.ByteIn;
              we_d        = 1'b1;
              wadr_d      = widx_q[ADDR_W-1:0];
              wdata_d     = {word_q[31:8], bus.ByteIn};
              widx_d      = widx_q + 1'b1;
              if (last_word) state_d = S_CHK;
            end
          endcase
        end
      end
      S_CHK: begin
        if (accept) state_d = (bus.ByteIn == csum_q) ? S_DONE : S_ERR;
      end
      default: state_d = S_IDLE;
    endcase

    // Any accept restarts the idle count. A stall that reaches the limit aborts the session.
    if (active && (TIMEOUT_CYC != 0)) begin
      if (accept) begin
        tmo_d = '0;
      end else begin
        tmo_d = tmo_q + 32'd1;
        if (tmo_q == TIMEOUT_CYC - 1) state_d = S_ERR;
      end
    end
  end

  // State register. Reset clears everything, including any pending write strobe.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= S_IDLE;
      count_q <= '0;
      widx_q  <= '0;
      bidx_q  <= '0;
      csum_q  <= '0;
      word_q  <= '0;
      tmo_q   <= '0;
      we_q    <= 1'b0;
      wadr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      widx_q  <= widx_d;
      bidx_q  <= bidx_d;
      csum_q  <= csum_d;
      word_q  <= word_d;
      tmo_q   <= tmo_d;
      we_q    <= we_d;
      wadr_q  <= wadr_d;
      wdata_q <= wdata_d;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader.
// Stimulus tasks push the expected IM writes. A negedge monitor pops and compares them.
module tb_imem_loader;
  localparam int unsigned ADDR_W = 10;

  typedef struct {
    logic [ADDR_W-1:0] adr;
    logic [31:0]       data;
  } wr_t;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  wr_t  exp_q[$];

  imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

  imem_loader #(.ADDR_W(ADDR_W), .DEPTH(1024), .TIMEOUT_CYC(16)) dut (
    .Clk   (clk),
    .Reset (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: every IM write must match the next expected write.
  always @(negedge clk) begin
    if (bus.ImWe === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL imwe_unexpected adr=%0h data=%08h", bus.ImWAdr, bus.ImWData);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if (bus.ImWAdr !== e.adr || bus.ImWData !== e.data) begin
          failures++;
          $display("FAIL imwe_word got adr=%0h data=%08h exp adr=%0h data=%08h",
                   bus.ImWAdr, bus.ImWData, e.adr, e.data);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic push_wr(input logic [ADDR_W-1:0] a, input logic [31:0] d);
    wr_t e;
    e.adr  = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic start_pulse();
    @(negedge clk);
    bus.Start = 1'b1;
    @(negedge clk);
    bus.Start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    @(negedge clk);
    bus.ByteIn    = b;
    bus.ByteValid = 1'b1;
    n = 0;
    while (bus.ByteReady !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checks++;
      failures++;
      $display("FAIL byte_ready_timeout byte=%02h got_ready=%b exp_ready=1", b, bus.ByteReady);
      bus.ByteValid = 1'b0;
    end else begin
      @(posedge clk);
    end
  endtask

  // Drop ByteValid on the negedge after the last accept. Outputs then show post-edge state.
  task automatic end_frame();
    @(negedge clk);
    bus.ByteValid = 1'b0;
  endtask

  task automatic gap(input int n);
    @(negedge clk);
    bus.ByteValid = 1'b0;
    repeat (n) @(posedge clk);
  endtask

  task automatic send_frame1(input logic [7:0] chk_byte);
    logic [7:0] f [10];
    f = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
    for (int i = 0; i < 10; i++) send_byte(f[i]);
    chk("hold_before_chk", {31'b0, bus.CpuHold}, 32'd1);
    send_byte(chk_byte);
    end_frame();
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit bad;
    checks        = 0;
    failures      = 0;
    bus.Start     = 1'b0;
    bus.ByteIn    = 8'h00;
    bus.ByteValid = 1'b0;
    rst           = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'b0, bus.ByteReady}, 32'd0);
    chk("rst_status", {28'b0, bus.CpuHold, bus.Busy, bus.Done, bus.Err}, 32'd0);
    chk("rst_wport", {21'b0, bus.ImWe, bus.ImWAdr}, 32'd0);
    chk("rst_wdata", bus.ImWData, 32'd0);
    rst = 1'b0;

    // Test 1: a two-word frame with a good checksum.
    push_wr(10'd0, 32'h12345678);
    push_wr(10'd1, 32'h9ABCDEF0);
    start_pulse();
    chk("t1_busy_hold", {30'b0, bus.Busy, bus.CpuHold}, 32'h3);
    send_frame1(8'h02);
    chk("t1_status", {28'b0, bus.CpuHold, bus.Busy, bus.Done, bus.Err}, 32'b0010);
    chk("t1_adr_hold", {22'b0, bus.ImWAdr}, 32'd1);
    chk("t1_data_hold", bus.ImWData, 32'h9ABCDEF0);
    chk("t1_queue_empty", exp_q.size(), 32'd0);

    // Test 2: an empty frame.
    start_pulse();
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    end_frame();
    chk("t2_status", {28'b0, bus.CpuHold, bus.Busy, bus.Done, bus.Err}, 32'b0010);

    // Test 3: a count greater than DEPTH.
    start_pulse();
    send_byte(8'h04); send_byte(8'h01);
    end_frame();
    chk("t3_status", {28'b0, bus.CpuHold, bus.Busy, bus.Done, bus.Err}, 32'b1001);
    chk("t3_ready", {31'b0, bus.ByteReady}, 32'd0);

    // Test 4: a bad checksum. Both writes still happen.
    push_wr(10'd0, 32'h12345678);
    push_wr(10'd1, 32'h9ABCDEF0);
    start_pulse();
    send_frame1(8'h03);
    chk("t4_status", {28'b0, bus.CpuHold, bus.Busy, bus.Done, bus.Err}, 32'b1001);
    chk("t4_queue_empty", exp_q.size(), 32'd0);

    // Test 5: gaps shorter than the timeout, then a stall.
    push_wr(10'd0, 32'h11223344);
    start_pulse();
    send_byte(8'h00); gap(3);
    send_byte(8'h02); gap(15);
    send_byte(8'h11); gap(7);
    send_byte(8'h22); gap(10);
    send_byte(8'h33); gap(1);
    send_byte(8'h44);
    @(negedge clk);
    bus.ByteValid = 1'b0;
    chk("t5_no_err_gaps", {31'b0, bus.Err}, 32'd0);
    bad = 1'b0;
    for (int i = 1; i <= 15; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.Err !== 1'b0) bad = 1'b1;
    end
    chk("t5_no_err_15_idle", {31'b0, bad}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("t5_err_16th_idle", {29'b0, bus.CpuHold, bus.Busy, bus.Err}, 32'b101);
    chk("t5_queue_empty", exp_q.size(), 32'd0);

    // Test 6: an asynchronous reset in the middle of word 1, then a full reload.
    push_wr(10'd0, 32'h12345678);
    start_pulse();
    send_byte(8'h00); send_byte(8'h02);
    send_byte(8'h12); send_byte(8'h34); send_byte(8'h56); send_byte(8'h78);
    send_byte(8'h9A); send_byte(8'hBC);
    @(negedge clk);
    bus.ByteValid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("t6_async_status", {27'b0, bus.ByteReady, bus.CpuHold, bus.Busy, bus.Done, bus.Err}, 32'd0);
    chk("t6_async_wport", {21'b0, bus.ImWe, bus.ImWAdr}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    chk("t6_queue_empty_a", exp_q.size(), 32'd0);
    push_wr(10'd0, 32'h12345678);
    push_wr(10'd1, 32'h9ABCDEF0);
    start_pulse();
    send_frame1(8'h02);
    chk("t6_status", {28'b0, bus.CpuHold, bus.Busy, bus.Done, bus.Err}, 32'b0010);
    chk("t6_queue_empty_b", exp_q.size(), 32'd0);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
